// File: rtl/matmul_pkg.sv
// Shared constants and helpers for the 8x8 matrix multiply cluster.
//   DIM / DATA_W / ADDR_W : result matrix geometry and element width
//   A_W / B_W             : operand element widths of matrix_mult_8x8
//   stream_state_t        : result streamer control states
//   rc_to_addr()          : (row, col) -> column-major result RAM address
package matmul_pkg;

  localparam int DIM    = 8;
  localparam int DATA_W = 19;
  localparam int ADDR_W = 6;
  localparam int A_W    = 8;
  localparam int B_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } stream_state_t;

  // Results are stored column-major: element (r,c) sits at DIM*c + r.
  function automatic int unsigned rc_to_addr(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned dim = DIM);
    return dim * c + r;
  endfunction

endpackage

// File: rtl/matrix_result_streamer_if.sv
// Result RAM read port plus the row-major output stream of the streamer.
//   rd_en/rd_addr  : streamer -> RAM read request
//   rd_data        : RAM -> streamer, valid one cycle after rd_en
//   out_data/out_valid/out_last : streamer -> consumer
//   out_ready      : consumer -> streamer
// modport master = streamer side, modport slave = RAM/consumer side.
interface matrix_result_streamer_if #(
  parameter int DATA_W = matmul_pkg::DATA_W,
  parameter int ADDR_W = matmul_pkg::ADDR_W
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;   // two's complement element
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output rd_en, rd_addr, out_data, out_valid, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_data, out_valid, out_last,
    output rd_data, out_ready
  );

endinterface

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO holding {last, data} words between the result RAM and the
// output register of the streamer.
//   clk, reset       : clock, async active-high reset
//   push, push_data  : write one word
//   pop              : drop the head word
//   head             : current head word (meaningless when count == 0)
//   count            : occupancy, 0..2
// Push into a full FIFO and pop from an empty one are ignored; the streamer's
// credit scheme never asks for either.
module stream_skid_fifo #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push_ok) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/matrix_result_streamer.sv
// Reads the column-major 8x8 result RAM of matrix_mult_8x8 after its done
// pulse and streams the elements out row-major over valid/ready.
//   clk, reset : clock, async active-high reset
//   start      : one-cycle pulse, accepted only while idle
//   bus        : master side of matrix_result_streamer_if (RAM read port
//                and output stream)
//   busy       : stream in progress
//   done       : one-cycle pulse after the final (64th) transfer
//   checksum   : only with RESULT_CHECKSUM_EN defined; sign-extended sum of
//                all transferred elements, stable from done to next start
//
// Datapath: RAM read (1 cycle) -> 2-entry FIFO -> output register.
// A read is issued only while FIFO occupancy plus reads in flight stays
// below 2, counting a FIFO entry that moves to the output register in the
// same cycle as already free. That keeps full throughput and makes FIFO
// overflow impossible whatever out_ready does.
module matrix_result_streamer #(
  parameter int DATA_W = matmul_pkg::DATA_W,
  parameter int DIM    = matmul_pkg::DIM,
  parameter int ADDR_W = matmul_pkg::ADDR_W
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  matrix_result_streamer_if.master bus,
  output logic busy,
  output logic done
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic signed [DATA_W+5:0] checksum
`endif
);

  import matmul_pkg::*;

  localparam int LG = $clog2(DIM);

  stream_state_t     state, state_nx;
  logic [ADDR_W-1:0] idx;
  logic              last_rd;
  logic              issue;
  logic              accept;

  logic              fly_vld;
  logic              fly_last;

  logic [DATA_W:0]   head;
  logic [1:0]        occ;
  logic              load;

  logic              out_valid_q;
  logic              out_last_q;
  logic [DATA_W-1:0] out_data_q;
  logic              xfer;

  assign accept  = (state == IDLE) && start;
  assign last_rd = (idx == {ADDR_W{1'b1}});
  assign xfer    = out_valid_q && bus.out_ready;
  // The output register refills from the FIFO whenever it is empty or
  // being emptied by a transfer in this cycle.
  assign load    = (occ != 2'd0) && (!out_valid_q || bus.out_ready);
  assign issue   = (state == RUN) &&
                   ((3'(occ) + 3'(fly_vld) - 3'(load)) < 3'd2);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (issue && last_rd) state_nx = DRAIN;
      DRAIN:   if (xfer && out_last_q) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- read side ----------------
  // idx walks row-major; it parks on the last element rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      fly_vld  <= 1'b0;
      fly_last <= 1'b0;
    end else begin
      if (accept)                idx <= '0;
      else if (issue && !last_rd) idx <= idx + 1'b1;
      fly_vld  <= issue;
      fly_last <= issue && last_rd;
    end
  end

  assign bus.rd_en   = issue;
  assign bus.rd_addr = ADDR_W'(rc_to_addr(32'(idx[ADDR_W-1:LG]),
                                          32'(idx[LG-1:0]), DIM));

  // ---------------- buffering ----------------
  stream_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fly_vld),
    .push_data ({fly_last, bus.rd_data}),
    .pop       (load),
    .head      (head),
    .count     (occ)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_last_q  <= head[DATA_W];
      out_data_q  <= head[DATA_W-1:0];
    end else if (xfer) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;

  // ---------------- status ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= (state == DRAIN) && xfer && out_last_q;
  end

  assign busy = (state != IDLE);

`ifdef RESULT_CHECKSUM_EN
  logic signed [DATA_W+5:0] acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       acc <= '0;
    else if (accept) acc <= '0;
    else if (xfer)   acc <= acc + {{6{out_data_q[DATA_W-1]}}, out_data_q};
  end

  assign checksum = acc;
`endif

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed/randomised bench for matrix_result_streamer. The result RAM is a
// behavioural array; expected output order is derived from the row-major
// over column-major addressing rule.
module tb_matrix_result_streamer;

  localparam int DW = 19;
  localparam int AW = 6;
  localparam int N  = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b1;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  matrix_result_streamer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

`ifdef RESULT_CHECKSUM_EN
  logic [DW+5:0] checksum;
`endif

  matrix_result_streamer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
`ifdef RESULT_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  logic [DW-1:0] mem [N];

  // Synchronous-read result RAM
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q [N];
  int            xfers, reads, dones, first_valid_k, done_k;
  logic          stall_prev, last_prev;
  logic [DW-1:0] hold_data, first_val, last_val;
  logic          hold_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output element i is row i/8, col i%8, stored at address 8*col + row.
  function automatic logic [AW-1:0] exp_addr(input int n);
    return AW'((n % 8) * 8 + n / 8);
  endfunction

  function automatic void build_exp();
    for (int i = 0; i < N; i++) exp_q[i] = mem[exp_addr(i)];
  endfunction

  function automatic logic [DW+5:0] exp_sum();
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'($signed(mem[i]));
    return (DW+6)'(s);
  endfunction

  function automatic logic ready_of(input int pat, input int k);
    case (pat)
      0:       return 1'b1;
      1:       return ((k % 4) == 0) || ((k % 4) == 3);
      2:       return 1'($urandom_range(0, 1));
      3:       return (k % 2) == 0;
      default: return k >= 40;
    endcase
  endfunction

  // One clock: entered just after a rising edge with inputs set; checks at
  // the falling edge, returns 1 time unit after the next rising edge.
  task automatic sample(input int k);
    logic xf;
    @(negedge clk);
    if (stall_prev) begin
      chk("hold_valid", bus.out_valid, 1'b1);
      chk("hold_data",  bus.out_data,  hold_data);
      chk("hold_last",  bus.out_last,  hold_last);
    end
    if (done) begin
      dones++;
      if (done_k < 0) done_k = k;
      chk("done_after_last", last_prev, 1'b1);
      chk("done_xfers", xfers, N);
    end
    if (bus.out_valid && first_valid_k < 0) first_valid_k = k;
    xf = bus.out_valid && bus.out_ready;
    if (xf) begin
      chk("xfer_in_range", xfers < N, 1'b1);
      if (xfers < N) begin
        chk("data", bus.out_data, exp_q[xfers]);
        chk("last", bus.out_last, xfers == N - 1);
      end
      if (xfers == 0) first_val = bus.out_data;
      last_val = bus.out_data;
      xfers++;
    end
    last_prev = xf && (xfers == N);
    if (bus.rd_en) begin
      chk("rd_in_range", reads < N, 1'b1);
      chk("rd_addr", bus.rd_addr, exp_addr(reads));
      reads++;
      chk("credit_bound", (reads - xfers) <= 3, 1'b1);
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    hold_data  = bus.out_data;
    hold_last  = bus.out_last;
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input int pat, input int restart_at, input int abort_at);
    bit restarted = 0;
    xfers = 0; reads = 0; dones = 0; first_valid_k = -1; done_k = -1;
    stall_prev = 0; last_prev = 0;
    build_exp();
    start = 1'b1;
    bus.out_ready = ready_of(pat, 0);
    sample(0);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("first_rd_en", bus.rd_en, 1'b1);
    for (int k = 1; k < 2000; k++) begin
      if (abort_at >= 0 && xfers >= abort_at) return;
      bus.out_ready = ready_of(pat, k);
      if (!restarted && restart_at >= 0 && xfers == restart_at) begin
        start = 1'b1;
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      if (pat == 4 && k == 39) begin
        chk("stall_rd_en", bus.rd_en, 1'b0);
        chk("stall_valid", bus.out_valid, 1'b1);
        chk("stall_no_xfer", xfers, 0);
      end
      sample(k);
      if (dones > 0) break;
    end
    start = 1'b0;
    chk("stream_done_seen", dones, 1);
    chk("done_pulse_width", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
    bus.out_ready = 1'b1;
    repeat (3) sample(3000);
    chk("single_done", dones, 1);
    chk("total_xfers", xfers, N);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = DW'(i);

    // Reset values, with start held alongside reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en",     bus.rd_en,     1'b0);
    chk("rst_rd_addr",   bus.rd_addr,   '0);
    chk("rst_out_data",  bus.out_data,  '0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_last",  bus.out_last,  1'b0);
    chk("rst_busy",      busy,          1'b0);
    chk("rst_done",      done,          1'b0);
`ifdef RESULT_CHECKSUM_EN
    chk("rst_checksum",  checksum,      '0);
`endif
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("start_during_reset_ignored", busy, 1'b0);

    // Identity load, full throughput
    run_stream(0, -1, -1);
    chk("first_valid_latency", first_valid_k, 4);
    chk("done_latency", done_k, 68);
    chk("ident_first", first_val, DW'(0));
    chk("ident_last", last_val, DW'(63));
`ifdef RESULT_CHECKSUM_EN
    chk("checksum_ident", checksum, 25'd2016);
`endif

    // Sign preservation with toggling ready
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    mem[0]  = 19'h40000;
    mem[63] = 19'h3FFFF;
    run_stream(3, -1, -1);
    chk("sign_first", first_val, 19'h40000);
    chk("sign_last",  last_val,  19'h3FFFF);
`ifdef RESULT_CHECKSUM_EN
    chk("checksum_rand", checksum, exp_sum());
`endif

    // Backpressure 1,0,0,1
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    run_stream(1, -1, -1);

    // Second start at element 10 is ignored
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    run_stream(0, 10, -1);

    // Long stall at the beginning, then drain
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    run_stream(4, -1, -1);

    // Random ready, all elements -1
    for (int i = 0; i < N; i++) mem[i] = '1;
    run_stream(2, -1, -1);
`ifdef RESULT_CHECKSUM_EN
    chk("checksum_neg", checksum, 25'h1FFFFC0);
`endif

    // Mid-stream reset after 20 transfers
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    run_stream(2, -1, 20);
    chk("abort_xfers", xfers, 20);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_busy",  busy,          1'b0);
    chk("mid_rst_rd_en", bus.rd_en,     1'b0);
    chk("mid_rst_last",  bus.out_last,  1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_done", done, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("no_done_after_rst", done, 1'b0);
    mem[0] = 19'h12345;
    run_stream(0, -1, -1);
    chk("restart_first", first_val, 19'h12345);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
